// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared constants, enums and decode helpers for the ALU control sequencer
package alu_ctrl_pkg;

  // ALU operation codes (4-bit core encoding, zero-extended to OP_W at the top)
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_MULH = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REM  = 4'b1110;
  localparam logic [3:0] OP_REMU = 4'b1111;

  // ALUOp values from the main control unit
  localparam logic [1:0] ALUOP_LOAD_STORE = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH     = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE      = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE      = 2'b11;

  // funct7 values that carry meaning for decode
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    LAT_ONE,
    LAT_MUL,
    LAT_DIV
  } lat_class_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_MC
  } state_t;

  // Base integer op selected by funct3 when funct7 is the plain encoding
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  // M-extension op by funct3; MULHSU/MULHU fold onto MULH, the MUL unit uses funct3
  function automatic logic [3:0] m_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = OP_MUL;
      3'b001,
      3'b010,
      3'b011:  op = OP_MULH;
      3'b100:  op = OP_DIV;
      3'b101:  op = OP_DIVU;
      3'b110:  op = OP_REM;
      default: op = OP_REMU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational ALUOp/funct7/funct3 decoder with latency class
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [1:0] alu_op,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [3:0] op_code,
  output logic       illegal,
  output lat_class_t lat_class
);

  // Decode table; unsupported combinations fall back to ADD with illegal set
  always_comb begin
    op_code   = OP_ADD;
    illegal   = 1'b0;
    lat_class = LAT_ONE;
    case (alu_op)
      ALUOP_LOAD_STORE: op_code = OP_ADD;
      ALUOP_BRANCH:     op_code = OP_SUB;
      ALUOP_RTYPE: begin
        if (funct7 == F7_BASE) begin
          op_code = base_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          op_code = OP_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          op_code = OP_SRA;
        end else if (funct7 == F7_MULDIV && EN_M) begin
          op_code   = m_op(funct3);
          lat_class = funct3[2] ? LAT_DIV : LAT_MUL;
        end else begin
          illegal = 1'b1;
        end
      end
      default: begin
        // I-type: funct7 is immediate bits except for the shift encodings
        case (funct3)
          3'b001: begin
            if (funct7 == F7_BASE) op_code = OP_SLL;
            else                   illegal = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     op_code = OP_SRL;
            else if (funct7 == F7_ALT) op_code = OP_SRA;
            else                       illegal = 1'b1;
          end
          default: op_code = base_op(funct3);
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered ALU control decoder with valid/ready output and MUL/DIV latency hold-off
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter bit EN_M    = 1'b1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] op_code,
  output logic            illegal,
  output logic            mc_busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT);

  // The counter holds remaining MC cycles minus one, so an L-cycle op loads L-2
  localparam logic [CNT_W-1:0] MUL_LOAD = (MUL_LAT >= 2) ? CNT_W'(MUL_LAT - 2) : '0;
  localparam logic [CNT_W-1:0] DIV_LOAD = (DIV_LAT >= 2) ? CNT_W'(DIV_LAT - 2) : '0;
  localparam bit               MUL_MC   = (MUL_LAT >= 2);
  localparam bit               DIV_MC   = (DIV_LAT >= 2);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       dec_op;
  logic             dec_ill;
  lat_class_t       dec_lat;
  logic             multi;
  logic [CNT_W-1:0] load_val;
  logic             accept;

  alu_ctrl_decode #(
    .EN_M(EN_M)
  ) u_decode (
    .alu_op   (alu_op),
    .funct7   (funct7),
    .funct3   (funct3),
    .op_code  (dec_op),
    .illegal  (dec_ill),
    .lat_class(dec_lat)
  );

  // Map the decoded latency class to an MC entry decision and counter preload
  always_comb begin
    multi    = 1'b0;
    load_val = '0;
    case (dec_lat)
      LAT_MUL: begin
        multi    = MUL_MC;
        load_val = MUL_LOAD;
      end
      LAT_DIV: begin
        multi    = DIV_MC;
        load_val = DIV_LOAD;
      end
      default: ;
    endcase
  end

  // Handshake, next-state and counter update
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_HOLD: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid && in_ready;
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          state_nxt = multi ? ST_MC : ST_HOLD;
          cnt_nxt   = multi ? load_val : '0;
        end else if (state == ST_HOLD && out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_MC: begin
        if (cnt == '0) state_nxt = ST_HOLD;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and latency counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Output register captures the decode result at the accepting edge only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_code <= '0;
      illegal <= 1'b0;
    end else if (accept) begin
      op_code <= OP_W'(dec_op);
      illegal <= dec_ill;
    end
  end

  assign out_valid = (state == ST_HOLD);
  assign mc_busy   = (state == ST_MC);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - scoreboard bench for alu_ctrl_seq against a table-driven reference model
module tb_alu_ctrl_seq;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid, in_ready, out_valid, out_ready, illegal, mc_busy;
  logic [1:0] alu_op;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [3:0] op_code;

  logic       m_in_valid, m_in_ready, m_out_valid, m_illegal, m_mc_busy;
  logic [3:0] m_op_code;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.OP_W(4), .EN_M(1'b1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct7(funct7), .funct3(funct3),
    .out_valid(out_valid), .out_ready(out_ready), .op_code(op_code),
    .illegal(illegal), .mc_busy(mc_busy)
  );

  alu_ctrl_seq #(.OP_W(4), .EN_M(1'b0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut_nom (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .alu_op(alu_op), .funct7(funct7), .funct3(funct3),
    .out_valid(m_out_valid), .out_ready(out_ready), .op_code(m_op_code),
    .illegal(m_illegal), .mc_busy(m_mc_busy)
  );

  typedef struct {
    logic [3:0] op;
    logic       ill;
    int         lat;
    int         vis;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done = 1'b0;
  logic last_acc = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: RV32I/M instruction tables indexed by funct3
  function automatic void ref_model(input logic [1:0] a, input logic [6:0] f7, input logic [2:0] f3,
                                    input bit en_m, output logic [3:0] op, output logic ill, output int lat);
    logic [3:0] base [8];
    logic [3:0] mext [8];
    base = '{4'h2, 4'h4, 4'h8, 4'h9, 4'h3, 4'h5, 4'h1, 4'h0};
    mext = '{4'hA, 4'hB, 4'hB, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    op  = 4'h2;
    ill = 1'b0;
    if (a == 2'd0) begin
      op = 4'h2;
    end else if (a == 2'd1) begin
      op = 4'h6;
    end else if (a == 2'd2) begin
      if (f7 == 7'h00)                         op = base[f3];
      else if (f7 == 7'h20 && f3 == 3'd0)      op = 4'h6;
      else if (f7 == 7'h20 && f3 == 3'd5)      op = 4'h7;
      else if (f7 == 7'h01 && en_m)            op = mext[f3];
      else                                     ill = 1'b1;
    end else begin
      if (f3 == 3'd1 && f7 != 7'h00)                      ill = 1'b1;
      else if (f3 == 3'd5 && f7 == 7'h20)                 op = 4'h7;
      else if (f3 == 3'd5 && f7 != 7'h00)                 ill = 1'b1;
      else                                                op = base[f3];
    end
    if (op >= 4'hC)      lat = DIV_LAT;
    else if (op >= 4'hA) lat = MUL_LAT;
    else                 lat = 1;
  endfunction

  // One clock of stimulus; entered just after a rising edge, returns just after the next
  task automatic step(input logic v, input logic [1:0] a, input logic [6:0] f7, input logic [2:0] f3,
                      input logic ordy);
    int         eacc;
    logic [3:0] e_op;
    logic       e_ill;
    int         e_lat;
    exp_t       e;
    in_valid  = v;
    alu_op    = a;
    funct7    = f7;
    funct3    = f3;
    out_ready = ordy;
    @(negedge clk);
    last_acc = in_valid && in_ready;
    eacc     = cyc + 1;
    @(posedge clk);
    if (last_acc) begin
      ref_model(a, f7, f3, 1'b1, e_op, e_ill, e_lat);
      e.op  = e_op;
      e.ill = e_ill;
      e.lat = e_lat;
      e.vis = eacc + e_lat - 1;
      sb.push_back(e);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op_code", op_code, 0);
    chk("rst_mc_busy", mc_busy, 0);
    chk("rst_illegal", illegal, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);
  endtask

  // Monitor: compares DUT outputs against the head of the expected queue every cycle
  initial begin
    while (!done) begin
      @(negedge clk);
      if (rst_n && !done) begin
        if (sb.size() == 0) begin
          chk("idle_out_valid", out_valid, 0);
          chk("idle_mc_busy", mc_busy, 0);
          chk("idle_in_ready", in_ready, 1);
        end else if (cyc < sb[0].vis) begin
          chk("wait_out_valid", out_valid, 0);
          chk("wait_mc_busy", mc_busy, (sb[0].lat > 1) ? 1 : 0);
          chk("wait_in_ready", in_ready, 0);
        end else begin
          chk("out_valid", out_valid, 1);
          chk("op_code", op_code, sb[0].op);
          chk("illegal", illegal, sb[0].ill);
          chk("hold_mc_busy", mc_busy, 0);
          chk("hold_in_ready", in_ready, out_ready);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    in_valid = 1'b0; alu_op = 2'b00; funct7 = 7'h00; funct3 = 3'b000;
    out_ready = 1'b0; m_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("por_out_valid", out_valid, 0);
    chk("por_op_code", op_code, 0);
    chk("por_mc_busy", mc_busy, 0);
    chk("por_illegal", illegal, 0);
    rst_n = 1'b1;
    #1 chk("por_in_ready", in_ready, 1);

    // R-type sweep, back-to-back
    step(1, 2'b10, 7'h20, 3'b000, 1);
    step(1, 2'b10, 7'h20, 3'b101, 1);
    step(1, 2'b10, 7'h00, 3'b111, 1);
    step(1, 2'b10, 7'h00, 3'b110, 1);
    step(0, 2'b00, 7'h00, 3'b000, 1);

    // MUL then DIV latency
    step(1, 2'b10, 7'h01, 3'b000, 1);
    repeat (4) step(0, 2'b00, 7'h00, 3'b000, 1);
    step(1, 2'b10, 7'h01, 3'b100, 1);
    repeat (9) step(0, 2'b00, 7'h00, 3'b000, 1);

    // Backpressure on SRAI, then release with a new op waiting
    step(1, 2'b11, 7'h20, 3'b101, 0);
    repeat (5) step(0, 2'b00, 7'h00, 3'b000, 0);
    step(1, 2'b10, 7'h00, 3'b111, 1);
    chk("release_accept", last_acc, 1);
    step(0, 2'b00, 7'h00, 3'b000, 1);

    // Illegal funct7
    step(1, 2'b10, 7'h7f, 3'b000, 1);
    step(0, 2'b00, 7'h00, 3'b000, 1);

    // Reset while holding
    step(1, 2'b01, 7'h00, 3'b000, 0);
    step(0, 2'b00, 7'h00, 3'b000, 0);
    do_reset();

    // Reset during a DIV; the result must never appear
    step(1, 2'b10, 7'h01, 3'b100, 1);
    repeat (3) step(0, 2'b00, 7'h00, 3'b000, 1);
    do_reset();
    repeat (12) step(0, 2'b00, 7'h00, 3'b000, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [6:0] f7;
      int         r;
      r  = $urandom_range(0, 3);
      f7 = (r == 0) ? 7'h00 : (r == 1) ? 7'h20 : (r == 2) ? 7'h01 : 7'($urandom);
      step(($urandom_range(0, 9) < 7), 2'($urandom), f7, 3'($urandom), ($urandom_range(0, 9) < 6));
    end
    repeat (DIV_LAT + 2) step(0, 2'b00, 7'h00, 3'b000, 1);

    // M ops on the EN_M=0 instance are illegal and single-cycle
    alu_op = 2'b10; funct7 = 7'h01; funct3 = 3'b100; out_ready = 1'b1; m_in_valid = 1'b1;
    @(negedge clk);
    chk("nom_in_ready", m_in_ready, 1);
    @(posedge clk);
    #1 m_in_valid = 1'b0;
    chk("nom_out_valid", m_out_valid, 1);
    chk("nom_illegal", m_illegal, 1);
    chk("nom_op_code", m_op_code, 4'h2);
    chk("nom_mc_busy", m_mc_busy, 0);
    @(posedge clk);
    #1 chk("nom_drained", m_out_valid, 0);

    done = 1'b1;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Parametrised, registered successor to the combinational ALU control decoder.
- Decodes ALUOp, funct7 and funct3 into an ALU operation code, covering full RV32I plus optional M-extension ops.
- Output is held in a valid/ready register; multi-cycle ops (MUL/DIV) are held off by a latency counter.
- Sits between the main control/ID stage and the EX-stage ALU and multiply/divide unit.

Parameters:
- OP_W, 4, operation-code width (must be >= 4; upper bits zero-extended).
- EN_M, 1, 1 = decode M-extension ops; 0 = flag them illegal.
- MUL_LAT, 3, cycles from acceptance to out_valid for MUL/MULH/MULHSU/MULHU (>= 1).
- DIV_LAT, 8, same for DIV/DIVU/REM/REMU (>= 1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  upstream has a decode request.
- in_ready  out  1  block accepts the request this cycle.
- alu_op  in  2  {ALUOp1, ALUOp0}.
- funct7  in  7  instr[31:25].
- funct3  in  3  instr[14:12].
- out_valid  out  1  op_code/illegal valid.
- out_ready  in  1  downstream consumes the output.
- op_code  out  OP_W  ALU operation code.
- illegal  out  1  decoded combination unsupported.
- mc_busy  out  1  multi-cycle op in progress.

Behaviour:
- Encodings: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001, MUL 1010, MULH 1011, DIV 1100, DIVU 1101, REM 1110, REMU 1111.
- MULHSU and MULHU both map to MULH (1011); the MUL unit distinguishes them with funct3.
- Decode:
  - alu_op=00: ADD.
  - alu_op=01: SUB.
  - alu_op=10 (R-type): funct7=0000000 selects by funct3 (ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND). funct7=0100000 with funct3 000 gives SUB; with 101 gives SRA. funct7=0000001 with EN_M=1 selects M ops by funct3.
  - alu_op=11 (I-type): funct3 selects. funct3=000 is ADD irrespective of funct7. For funct3=001 funct7 must be 0000000. For funct3=101, funct7=0000000 gives SRL and 0100000 gives SRA.
  - Any other combination: illegal=1, op_code=ADD, treated as single-cycle. No X/Z is ever driven.
- Latency class L:
  - MUL group: L = MUL_LAT.
  - DIV group: L = DIV_LAT.
  - All others: L = 1.
- Reset (async, rst_n=0): state IDLE, out_valid=0, op_code=0, illegal=0, mc_busy=0, counter=0.
- FSM states:
  - IDLE: out empty; in_ready=1.
  - HOLD: out_valid=1; in_ready=out_ready.
  - MC: mc_busy=1, out_valid=0, in_ready=0.
- Accept on in_valid && in_ready; the decode result is captured at that edge.
  - L=1: next state HOLD, so out_valid is high from edge k+1 (k = accept edge).
  - L>=2: next state MC, counter loaded with L-2. Decrement each MC cycle. When MC has counter==0, go to HOLD at the next edge, so out_valid rises at edge k+L.
- HOLD:
  - out_ready=1 with no accept: go to IDLE.
  - out_ready=1 with accept (back-to-back): go straight to the new op's state.
  - out_ready=0: hold op_code/illegal stable.
- mc_busy equals (state==MC).
- Counter width is $clog2(max(MUL_LAT,DIV_LAT)) with a minimum of 1.
- Async reset mid-MC or mid-HOLD aborts immediately; the pending op is discarded.

Decomposition:
- Package alu_ctrl_pkg: op-code localparams, ALUOp constants (LOAD_STORE, BRANCH, RTYPE, ITYPE), funct7 constants (BASE, ALT, MULDIV), FSM state enum.
- Sub-module alu_ctrl_decode: purely combinational. Inputs alu_op/funct7/funct3 and EN_M; outputs op_code, illegal, lat_class.
- The top level holds the FSM, counter and output register.

Test Plan:
- Reset: rst_n=0 mid-stream -> out_valid=0, op_code=0, mc_busy=0 immediately; in_ready=1 after release.
- R-type sweep with out_ready=1 (alu_op=10): funct7=0100000/funct3=000 -> 0110; funct3=101 -> 0111; funct7=0000000/funct3=111 -> 0000; funct3=110 -> 0001. Each gives out_valid 1 cycle after accept, back-to-back at 1 op/cycle.
- MUL (funct7=0000001, funct3=000, MUL_LAT=3): mc_busy=1 and in_ready=0 for cycles k+1..k+2; out_valid=1 with op_code=1010 at k+3. DIV with DIV_LAT=8 -> 1100 at k+8.
- Backpressure: out_ready=0 for 5 cycles after an I-type SRAI (alu_op=11, funct3=101, funct7=0100000) -> op_code=0111 held stable, in_ready=0; releasing out_ready with in_valid high accepts the next op in the same cycle.
- Illegal: alu_op=10, funct7=1111111 -> illegal=1, op_code=0010; EN_M=0 with MUL -> illegal=1, single-cycle, mc_busy stays 0.
- Reset during MC (DIV, reset at k+4) -> state IDLE; the DIV result is never presented.
